// File: rtl/dc_removal_mc_if.sv
// Sample stream bundle for dc_removal_mc: tagged ADC input samples and DC-corrected output samples.
interface dc_removal_mc_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned CH_W       = 1
);
    logic                         in_valid;
    logic [CH_W-1:0]              in_ch;
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         out_valid;
    logic [CH_W-1:0]              out_ch;
    logic signed [DATA_WIDTH:0]   data_out;
    logic [DATA_WIDTH-1:0]        dc_est;

    modport master (
        output in_valid, in_ch, data_in,
        input  out_valid, out_ch, data_out, dc_est
    );

    modport slave (
        input  in_valid, in_ch, data_in,
        output out_valid, out_ch, data_out, dc_est
    );
endinterface

// File: rtl/dc_removal_mc.sv
// Multi-channel DC remover: per-channel block-average or leaky-integrator DC estimate,
// subtracted from each time-multiplexed ADC sample with one cycle of latency.
module dc_removal_mc #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned LOG2_WINDOW = 10,
    parameter int unsigned IIR_SHIFT   = 8
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              stable,
    input  logic              mode,
    dc_removal_mc_if.slave    bus,
    output logic [NUM_CH-1:0] ch_ready
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW   = DATA_WIDTH + LOG2_WINDOW;
    localparam int unsigned IW   = DATA_WIDTH + IIR_SHIFT;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, ACQ, RUN} state_t;

    state_t                   state_q;
    logic                     mode_q;
    logic [AW-1:0]            acc_q  [NUM_CH];
    logic [LOG2_WINDOW-1:0]   cnt_q  [NUM_CH];
    logic [IW-1:0]            iacc_q [NUM_CH];
    logic [DATA_WIDTH-1:0]    est_q  [NUM_CH];
    logic [NUM_CH-1:0]        ch_ready_q;

    logic                     out_valid_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [DATA_WIDTH:0] data_out_q;
    logic [DATA_WIDTH-1:0]    dc_est_q;

    logic                     accept;
    logic [CH_W-1:0]          ch;
    logic                     eff_mode;
    logic [DATA_WIDTH-1:0]    dc_est_d;
    logic signed [DATA_WIDTH:0] data_out_d;
    logic [AW-1:0]            acc_sum;
    logic [IW-1:0]            iacc_d;

    // In IDLE the mode input is used directly so a sample in the acquire cycle sees the mode being latched.
    always_comb begin
        ch       = bus.in_ch;
        accept   = bus.in_valid && stable && ({1'b0, bus.in_ch} < NUM_CH_L);
        eff_mode = (state_q == IDLE) ? mode : mode_q;
        acc_sum  = '0;
        iacc_d   = '0;
        dc_est_d = '0;
        if (accept) begin
            acc_sum  = acc_q[ch] + AW'(bus.data_in);
            iacc_d   = iacc_q[ch] + IW'(bus.data_in) - (iacc_q[ch] >> IIR_SHIFT);
            dc_est_d = eff_mode ? iacc_q[ch][IW-1 -: DATA_WIDTH] : est_q[ch];
        end
        data_out_d = $signed({1'b0, bus.data_in}) - $signed({1'b0, dc_est_d});
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n || !stable) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            ch_ready_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
                iacc_q[i] <= '0;
                est_q[i]  <= '0;
            end
            if (!rst_n) begin
                mode_q     <= 1'b0;
                out_ch_q   <= '0;
                data_out_q <= '0;
                dc_est_q   <= '0;
            end
        end else begin
            out_valid_q <= accept && ch_ready_q[ch];
            case (state_q)
                IDLE: begin
                    mode_q  <= mode;
                    state_q <= ACQ;
                end
                ACQ: begin
                    if (&ch_ready_q) state_q <= RUN;
                end
                default: ;
            endcase

            if (accept) begin
                if (ch_ready_q[ch]) begin
                    out_ch_q   <= ch;
                    data_out_q <= data_out_d;
                    dc_est_q   <= dc_est_d;
                end
                if (eff_mode) begin
                    if (!ch_ready_q[ch]) begin
                        iacc_q[ch]     <= IW'(bus.data_in) << IIR_SHIFT;
                        ch_ready_q[ch] <= 1'b1;
                    end else begin
                        iacc_q[ch] <= iacc_d;
                    end
                end else if (&cnt_q[ch]) begin
                    est_q[ch]      <= acc_sum[AW-1 -: DATA_WIDTH];
                    acc_q[ch]      <= '0;
                    cnt_q[ch]      <= '0;
                    ch_ready_q[ch] <= 1'b1;
                end else begin
                    acc_q[ch] <= acc_sum;
                    cnt_q[ch] <= cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.data_out  = data_out_q;
    assign bus.dc_est    = dc_est_q;
    assign ch_ready      = ch_ready_q;
endmodule

// File: doc/dc_removal_mc.md
Name: dc_removal_mc

Overview:
Multi-channel, mode-selectable successor to the single-channel DC remover. It accepts time-multiplexed unsigned ADC samples tagged with a channel index and keeps an independent DC estimate per channel. Each sample is emitted with its channel's DC estimate subtracted, as a signed value. It sits between the ADC capture front-end and the FFT/measurement chain, all in the adc_clk domain.

Parameters:
DATA_WIDTH, 12, ADC sample width (unsigned input).
NUM_CH, 2, number of interleaved channels (1..16).
LOG2_WINDOW, 10, block-average window is 2^LOG2_WINDOW samples per channel.
IIR_SHIFT, 8, leaky-integrator time constant of 2^IIR_SHIFT samples in IIR mode.

Ports:
adc_clk  in  1  sole clock; all logic on its rising edge.
rst_n  in  1  synchronous, active-low reset.
stable  in  1  ADC/PLL settled. 0 holds the block in re-acquire.
mode  in  1  0 = block average, 1 = IIR. Latched on a 0->1 edge of stable.
in_valid  in  1  data_in/in_ch are valid this cycle.
in_ch  in  max(1,$clog2(NUM_CH))  channel tag of data_in.
data_in  in  DATA_WIDTH  unsigned sample.
out_valid  out  1  data_out/out_ch/dc_est are valid (one-cycle pulse per sample).
out_ch  out  max(1,$clog2(NUM_CH))  channel of the output sample.
data_out  out  DATA_WIDTH+1 signed  data_in minus the channel's DC estimate.
dc_est  out  DATA_WIDTH  DC estimate used for this output sample.
ch_ready  out  NUM_CH  per-channel flag: estimate valid.

Behaviour:
- Reset (rst_n=0 at the clock edge): the following are cleared to 0: all outputs, mode_q, per-channel accumulators, counters, estimates and ch_ready. The reset overrides every other input in that cycle.
- A sample is accepted when in_valid & stable & (in_ch < NUM_CH). Samples with an out-of-range in_ch are dropped silently and cause no state change.
- Latency is 1 cycle. Outputs are registered in the cycle after acceptance. out_valid=1 only if ch_ready[ch] was already 1 before the sample; otherwise out_valid=0.
- data_out = {1'b0,data_in} - {1'b0,est_old}, where est_old is the channel's estimate before this sample updates it. Range ±(2^DATA_WIDTH-1), so no saturation is needed. dc_est = est_old.
- Block mode (mode_q=0), per-channel state:
  - acc is DATA_WIDTH+LOG2_WINDOW bits wide; cnt is LOG2_WINDOW bits wide.
  - On each accepted sample: acc += data_in and cnt++.
  - When cnt wraps from all-ones (the 2^LOG2_WINDOW-th sample): est <= (acc+data_in)>>LOG2_WINDOW (truncated), acc <= 0, cnt <= 0, ch_ready[ch] <= 1 (sticky).
  - The estimate then refreshes every window; the output of the wrapping sample still uses est_old.
- IIR mode (mode_q=1), per-channel state:
  - iacc is DATA_WIDTH+IIR_SHIFT bits wide.
  - First accepted sample after acquire: iacc <= data_in<<IIR_SHIFT and ch_ready[ch] <= 1. No output is produced for this sample.
  - Subsequent samples: iacc <= iacc + data_in - (iacc>>IIR_SHIFT). est = iacc>>IIR_SHIFT (truncated) is the value used as est_old for the next sample.
- Acquire control (state machine per block):
  - States: IDLE -> ACQ -> RUN.
  - IDLE: entered on reset or when stable=0. Clears acc/cnt/iacc/est/ch_ready for all channels and suppresses out_valid.
  - On stable=1 while in IDLE: latch mode_q <= mode and go to ACQ.
  - ACQ -> RUN when all channels have ch_ready=1. RUN is informational only; per-channel gating uses ch_ready.
  - mode changes while stable=1 are ignored.
  - stable dropping mid-window discards the partial window.
- Channels are fully independent. Interleave order is arbitrary. Back-to-back samples on the same channel in consecutive cycles must work, including read-modify-write on the same channel every cycle.

Test Plan:
Bench settings: DATA_WIDTH=12, NUM_CH=2, LOG2_WINDOW=4, IIR_SHIFT=4. Scenarios:
1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, ch_ready=0, data_out=0. After release with stable=0, samples produce no output.
2. Block mode, ch0 at constant 1000 for 16 samples -> no out_valid and ch_ready[0]=1 after the 16th. 17th sample of 1200 -> out_valid, data_out=+200, dc_est=1000.
3. Ramp 0..15 on ch0, then 0 -> est=120>>4=7, so data_out=-7. Alternating ch0=1500 / ch1=200 for 32 samples -> both ready. Then ch1=4095 -> data_out=3895, out_ch=1. in_ch=2 -> ignored, no counter change.
4. IIR mode, ch0 constant 2048 for 3 samples -> 1st no output, then data_out=0. Step input to 2208 -> data_out=+160. Next 2208 -> est=(32768+160)>>4=2058, so data_out=+150.
5. Block mode: 10 samples, then stable=0 for 1 cycle, then stable=1 -> ch_ready cleared and 16 fresh samples are needed. mode toggled while stable=1 -> no effect.
6. Same channel every cycle for 48 cycles at alternating 1000/1010 -> est=1005 and outputs ±5 with no dropped updates.
